pipeline_hazard_unit: RTL and testbench

Controller end of the pipeline stage interface: drives the per-stage `nullify`, `stall` and `bubble` signals that every pipeline stage register consumes. It detects load-use hazards, memory-wait stalls and HI/LO hazards. It tracks the multi-cycle multiplier/divider with an internal busy state machine and flushes on exceptions and redirects. It sits beside the five stage registers (fetch, decode, execute, memory, writeback) and is the sole driver of their controller modport.

---
 rtl/pipeline_hazard_unit_pkg.sv | 34 +++
 rtl/pipeline_hazard_unit_muldiv_busy_tracker.sv | 65 ++++++
 rtl/pipeline_hazard_unit.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared hazard-unit definitions: stage indices, muldiv FSM states and
// the per-stage stall/bubble/nullify masks used by the priority encoder.
package hazard_info;

  localparam int unsigned STAGE_FETCH     = 0;
  localparam int unsigned STAGE_DECODE    = 1;
  localparam int unsigned STAGE_EXECUTE   = 2;
  localparam int unsigned STAGE_MEMORY    = 3;
  localparam int unsigned STAGE_WRITEBACK = 4;
  localparam int unsigned NUM_STAGES      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Exception squashes everything younger than writeback
  localparam logic [NUM_STAGES-1:0] NULLIFY_EXC      = 5'b01111;
  localparam logic [NUM_STAGES-1:0] NULLIFY_REDIRECT = 5'b00001;

  // Memory wait freezes fetch..memory, writeback receives a NOP
  localparam logic [NUM_STAGES-1:0] STALL_MEM        = 5'b01111;
  localparam logic [NUM_STAGES-1:0] BUBBLE_MEM       = 5'b10000;

  // HI/LO hazard freezes fetch..execute, memory receives a NOP
  localparam logic [NUM_STAGES-1:0] STALL_HILO       = 5'b00111;
  localparam logic [NUM_STAGES-1:0] BUBBLE_HILO      = 5'b01000;

  // Load-use freezes fetch..decode, execute receives a NOP
  localparam logic [NUM_STAGES-1:0] STALL_LOAD       = 5'b00011;
  localparam logic [NUM_STAGES-1:0] BUBBLE_LOAD      = 5'b00100;

endpackage

// File: rtl/pipeline_hazard_unit_muldiv_busy_tracker.sv
// Multiplier/divider occupancy tracker: IDLE -> BUSY (N cycles) -> DONE.
// A start is accepted from IDLE or DONE unless suppressed.
module muldiv_busy_tracker
  import hazard_info::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic suppress,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  muldiv_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          go;

  // Next-state and counter update; counter holds at zero, never wraps
  always_comb begin
    go      = start && !suppress;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = BUSY;
          cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers, asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard controller: priority-encodes exception, memory wait,
// HI/LO and load-use hazards into per-stage stall/bubble/nullify.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_unit
  import hazard_info::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  decode_rs,
  input  logic [4:0]  decode_rt,
  input  logic        decode_use_rs,
  input  logic        decode_use_rt,
  input  logic [4:0]  execute_dest_reg,
  input  logic        execute_is_load,
  input  logic        execute_muldiv_start,
  input  logic        execute_is_div,
  input  logic        execute_reads_hilo,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        exception,
  input  logic        redirect,
  output logic [4:0]  stall,
  output logic [4:0]  bubble,
  output logic [4:0]  nullify,
  output logic        muldiv_busy,
  output logic        muldiv_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_bubble_count
`endif
);

  logic load_use;
  logic mem_wait;
  logic hilo_hazard;
  logic start_suppress;

  // Hazard detection terms
  always_comb begin
    mem_wait    = mem_req && !mem_ready;
    hilo_hazard = muldiv_busy && (execute_reads_hilo || execute_muldiv_start);
    load_use    = execute_is_load && (execute_dest_reg != '0) &&
                  ((decode_use_rs && (decode_rs == execute_dest_reg)) ||
                   (decode_use_rt && (decode_rt == execute_dest_reg)));
  end

  // Priority encoder; redirect only squashes fetch when fetch is not held
  always_comb begin
    stall   = '0;
    bubble  = '0;
    nullify = '0;
    if (exception) begin
      nullify = NULLIFY_EXC;
    end else begin
      if (mem_wait) begin
        stall  = STALL_MEM;
        bubble = BUBBLE_MEM;
      end else if (hilo_hazard) begin
        stall  = STALL_HILO;
        bubble = BUBBLE_HILO;
      end else if (load_use) begin
        stall  = STALL_LOAD;
        bubble = BUBBLE_LOAD;
      end
      if (redirect && !stall[STAGE_FETCH]) begin
        nullify = NULLIFY_REDIRECT;
      end
    end
  end

  // A start is only taken when execute advances and no exception commits
  always_comb begin
    start_suppress = exception || stall[STAGE_EXECUTE];
  end

  muldiv_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .start    (execute_muldiv_start),
    .is_div   (execute_is_div),
    .suppress (start_suppress),
    .busy     (muldiv_busy),
    .done     (muldiv_done)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] bubble_count_q, bubble_count_d;
  logic [32:0] bubble_sum;

  // Saturating statistics update
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall != '0) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    bubble_sum     = {1'b0, bubble_count_q} + 33'($countones(bubble));
    bubble_count_d = bubble_sum[32] ? '1 : bubble_sum[31:0];
  end

  // Statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stat_stall_cycles = stall_cycles_q;
  assign stat_bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit (MULT_CYCLES=4, DIV_CYCLES=32).
// Stimulus pushes the expected per-cycle outputs; a negedge monitor checks.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] decode_rs, decode_rt, execute_dest_reg;
  logic       decode_use_rs, decode_use_rt;
  logic       execute_is_load, execute_muldiv_start, execute_is_div;
  logic       execute_reads_hilo, mem_req, mem_ready, exception, redirect;
  logic [4:0] stall, bubble, nullify;
  logic       muldiv_busy, muldiv_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cycles, stat_bubble_count;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_unit #(
    .MULT_CYCLES (4),
    .DIV_CYCLES  (32)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .decode_rs            (decode_rs),
    .decode_rt            (decode_rt),
    .decode_use_rs        (decode_use_rs),
    .decode_use_rt        (decode_use_rt),
    .execute_dest_reg     (execute_dest_reg),
    .execute_is_load      (execute_is_load),
    .execute_muldiv_start (execute_muldiv_start),
    .execute_is_div       (execute_is_div),
    .execute_reads_hilo   (execute_reads_hilo),
    .mem_req              (mem_req),
    .mem_ready            (mem_ready),
    .exception            (exception),
    .redirect             (redirect),
    .stall                (stall),
    .bubble               (bubble),
    .nullify              (nullify),
    .muldiv_busy          (muldiv_busy),
    .muldiv_done          (muldiv_done)
`ifdef HAZARD_STATS_EN
    ,
    .stat_stall_cycles    (stat_stall_cycles),
    .stat_bubble_count    (stat_bubble_count)
`endif
  );

  typedef struct {
    string       name;
    logic [16:0] v;   // {stall, bubble, nullify, busy, done}
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  exp_t        mon_e;
  logic [16:0] mon_act;

  localparam logic [4:0] Z = 5'b00000;

  // Monitor: compare one expected entry per cycle, away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = {stall, bubble, nullify, muldiv_busy, muldiv_done};
      checks++;
      if (mon_act !== mon_e.v) begin
        errors++;
        $display("FAIL %s: got stall=%b bubble=%b nullify=%b busy=%b done=%b, want stall=%b bubble=%b nullify=%b busy=%b done=%b",
                 mon_e.name, mon_act[16:12], mon_act[11:7], mon_act[6:2], mon_act[1], mon_act[0],
                 mon_e.v[16:12], mon_e.v[11:7], mon_e.v[6:2], mon_e.v[1], mon_e.v[0]);
      end
    end
  end

  task automatic clear_inputs();
    decode_rs            = '0;
    decode_rt            = '0;
    decode_use_rs        = 1'b0;
    decode_use_rt        = 1'b0;
    execute_dest_reg     = '0;
    execute_is_load      = 1'b0;
    execute_muldiv_start = 1'b0;
    execute_is_div       = 1'b0;
    execute_reads_hilo   = 1'b0;
    mem_req              = 1'b0;
    mem_ready            = 1'b0;
    exception            = 1'b0;
    redirect             = 1'b0;
  endtask

  // Inputs are already applied; record expectation and advance one cycle
  task automatic tick(input string nm, input logic [4:0] s, input logic [4:0] b,
                      input logic [4:0] n, input logic bz, input logic dn);
    exp_t e;
    e.name = nm;
    e.v    = {s, b, n, bz, dn};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] dest, input logic [4:0] rs,
                              input logic urs, input logic [4:0] rt, input logic urt);
    execute_is_load  = 1'b1;
    execute_dest_reg = dest;
    decode_rs        = rs;
    decode_use_rs    = urs;
    decode_rt        = rt;
    decode_use_rt    = urt;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick("reset_state", Z, Z, Z, 1'b0, 1'b0);
    reset = 1'b0;
    tick("idle", Z, Z, Z, 1'b0, 1'b0);

    // Load-use on rs, then gone the next cycle
    set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    tick("loaduse_rs", 5'b00011, 5'b00100, Z, 1'b0, 1'b0);
    clear_inputs();
    tick("loaduse_release", Z, Z, Z, 1'b0, 1'b0);
    set_load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    tick("loaduse_rt", 5'b00011, 5'b00100, Z, 1'b0, 1'b0);
    set_load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b0);
    tick("loaduse_rt_unused", Z, Z, Z, 1'b0, 1'b0);
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    tick("loaduse_dest0", Z, Z, Z, 1'b0, 1'b0);
    clear_inputs();

    // Redirect alone and combined with stalls
    redirect = 1'b1;
    tick("redirect_alone", Z, Z, 5'b00001, 1'b0, 1'b0);
    set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    tick("redirect_loaduse", 5'b00011, 5'b00100, Z, 1'b0, 1'b0);
    clear_inputs();
    mem_req = 1'b1;
    redirect = 1'b1;
    tick("redirect_memwait", 5'b01111, 5'b10000, Z, 1'b0, 1'b0);
    clear_inputs();

    // Memory wait and its priority over load-use; ready means no stall
    mem_req = 1'b1;
    set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    tick("memwait_over_loaduse", 5'b01111, 5'b10000, Z, 1'b0, 1'b0);
    clear_inputs();
    mem_req   = 1'b1;
    mem_ready = 1'b1;
    tick("mem_ready_nostall", Z, Z, Z, 1'b0, 1'b0);
    clear_inputs();

    // Mult (T=c10) then mfhi at c12..c14 with memory wait at c12..c13
    execute_muldiv_start = 1'b1;
    tick("mult_start", Z, Z, Z, 1'b0, 1'b0);
    clear_inputs();
    tick("mult_busy1", Z, Z, Z, 1'b1, 1'b0);
    execute_reads_hilo = 1'b1;
    mem_req            = 1'b1;
    tick("mfhi_memwait1", 5'b01111, 5'b10000, Z, 1'b1, 1'b0);
    tick("mfhi_memwait2", 5'b01111, 5'b10000, Z, 1'b1, 1'b0);
    mem_req = 1'b0;
    tick("mfhi_hilo", 5'b00111, 5'b01000, Z, 1'b1, 1'b0);
    tick("mfhi_release_done", Z, Z, Z, 1'b0, 1'b1);
    clear_inputs();
    tick("mult_idle", Z, Z, Z, 1'b0, 1'b0);

    // Exception with simultaneous start is suppressed
    exception            = 1'b1;
    execute_muldiv_start = 1'b1;
    tick("exc_with_start", Z, Z, 5'b01111, 1'b0, 1'b0);
    clear_inputs();
    tick("exc_start_stays_idle", Z, Z, Z, 1'b0, 1'b0);

    // Exception during BUSY, restart from DONE, held start during BUSY
    execute_muldiv_start = 1'b1;
    tick("m2_start", Z, Z, Z, 1'b0, 1'b0);
    clear_inputs();
    exception = 1'b1;
    tick("m2_exc_busy", Z, Z, 5'b01111, 1'b1, 1'b0);
    clear_inputs();
    for (int i = 0; i < 3; i++) tick("m2_busy", Z, Z, Z, 1'b1, 1'b0);
    execute_muldiv_start = 1'b1;
    tick("m2_done_restart", Z, Z, Z, 1'b0, 1'b1);
    clear_inputs();
    tick("m3_busy1", Z, Z, Z, 1'b1, 1'b0);
    execute_muldiv_start = 1'b1;
    tick("m3_start_held", 5'b00111, 5'b01000, Z, 1'b1, 1'b0);
    clear_inputs();
    tick("m3_busy3", Z, Z, Z, 1'b1, 1'b0);
    tick("m3_busy4", Z, Z, Z, 1'b1, 1'b0);
    tick("m3_done", Z, Z, Z, 1'b0, 1'b1);
    tick("m3_idle", Z, Z, Z, 1'b0, 1'b0);

    // Div interrupted by asynchronous reset, then a full 32-cycle div
    execute_muldiv_start = 1'b1;
    execute_is_div       = 1'b1;
    tick("div_start", Z, Z, Z, 1'b0, 1'b0);
    clear_inputs();
    for (int i = 0; i < 5; i++) tick("div_busy_pre_reset", Z, Z, Z, 1'b1, 1'b0);
    reset = 1'b1;
    tick("div_async_reset", Z, Z, Z, 1'b0, 1'b0);
    reset = 1'b0;
    tick("div_after_reset", Z, Z, Z, 1'b0, 1'b0);
    execute_muldiv_start = 1'b1;
    execute_is_div       = 1'b1;
    tick("div2_start", Z, Z, Z, 1'b0, 1'b0);
    clear_inputs();
    for (int i = 0; i < 32; i++) tick("div2_busy", Z, Z, Z, 1'b1, 1'b0);
    tick("div2_done", Z, Z, Z, 1'b0, 1'b1);
    tick("div2_idle", Z, Z, Z, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
